// File: rtl/tiger_defines.sv
// Shared definitions for the tiger register file: register-number width, bank depth and FSM states.
`ifndef REGNUM_WIDTH
`define REGNUM_WIDTH 5
`endif

package tiger_defines;
  localparam int REGNUM_W     = `REGNUM_WIDTH;
  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W       = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;
endpackage

// File: rtl/tiger_regbank.sv
// Single-write, N-read register bank; write commits on the rising edge, reads are combinational.
// With ZERO_REG set, entry 0 ignores writes and always reads as zero.
module tiger_regbank import tiger_defines::*; #(
  parameter int DEPTH    = NUM_REGS_DEF,
  parameter int AW       = REGNUM_W,
  parameter int DW       = DATA_W,
  parameter int NR       = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [DW-1:0]          wdata,
  input  logic [NR-1:0][AW-1:0]  raddr,
  output logic [NR-1:0][DW-1:0]  rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && !(ZERO_REG && waddr == '0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NR; i++) begin
      if (ZERO_REG && raddr[i] == '0) rdata[i] = '0;
      else                            rdata[i] = mem[raddr[i]];
    end
  end

endmodule

// File: rtl/tiger_regfile.sv
// GPR + coprocessor register file with a post-reset clear sequencer; reads are registered (1 cycle), stall holds outputs.
// TIGER_REGFILE_BYPASS_EN selects write-through on same-edge read/write collisions.
module tiger_regfile import tiger_defines::*; #(
  parameter int                NUM_REGS    = NUM_REGS_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [REGNUM_W-1:0] readRegNumA,
  input  logic [REGNUM_W-1:0] readRegNumB,
  input  logic [REGNUM_W-1:0] readCopNum,
  input  logic                writeRegEn,
  input  logic                writeRegEnCop,
  input  logic [REGNUM_W-1:0] writeRegNum,
  input  logic [DATA_W-1:0]   writeRegData,
  output logic [DATA_W-1:0]   regDataA,
  output logic [DATA_W-1:0]   regDataB,
  output logic [DATA_W-1:0]   copData,
  output logic                initBusy
);

  rf_state_t           state, state_nxt;
  logic [REGNUM_W-1:0] clear_idx;
  logic                clearing;

  logic                gpr_we, cop_we;
  logic [REGNUM_W-1:0] bank_waddr;
  logic [DATA_W-1:0]   bank_wdata;

  logic [1:0][DATA_W-1:0] gpr_rd;
  logic [0:0][DATA_W-1:0] cop_rd;
  logic [DATA_W-1:0]      rd_a, rd_b, rd_c;

  assign clearing = (state == RF_CLEAR);
  assign initBusy = clearing;

  always_comb begin
    state_nxt = state;
    if (clearing && clear_idx == REGNUM_W'(NUM_REGS - 1)) begin
      state_nxt = RF_RUN;
    end
  end

  // The clear sequencer owns both write ports; the writeback port is ignored until RUN.
  always_comb begin
    gpr_we     = 1'b0;
    cop_we     = 1'b0;
    bank_waddr = writeRegNum;
    bank_wdata = writeRegData;
    if (clearing) begin
      gpr_we     = 1'b1;
      cop_we     = 1'b1;
      bank_waddr = clear_idx;
      bank_wdata = CLEAR_VALUE;
    end else if (!reset) begin
      gpr_we = writeRegEn;
      cop_we = writeRegEnCop;
    end
  end

  tiger_regbank #(
    .DEPTH(NUM_REGS), .AW(REGNUM_W), .DW(DATA_W), .NR(2), .ZERO_REG(1'b1)
  ) u_gpr (
    .clk   (clk),
    .we    (gpr_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr ({readRegNumB, readRegNumA}),
    .rdata (gpr_rd)
  );

  tiger_regbank #(
    .DEPTH(NUM_REGS), .AW(REGNUM_W), .DW(DATA_W), .NR(1), .ZERO_REG(1'b0)
  ) u_cop (
    .clk   (clk),
    .we    (cop_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (readCopNum),
    .rdata (cop_rd)
  );

`ifdef TIGER_REGFILE_BYPASS_EN
  always_comb begin
    rd_a = gpr_rd[0];
    rd_b = gpr_rd[1];
    rd_c = cop_rd[0];
    if (writeRegEn && writeRegNum == readRegNumA && readRegNumA != '0) rd_a = writeRegData;
    if (writeRegEn && writeRegNum == readRegNumB && readRegNumB != '0) rd_b = writeRegData;
    if (writeRegEnCop && writeRegNum == readCopNum)                    rd_c = writeRegData;
  end
`else
  // Colliding reads see pre-write contents; the hazard unit covers the gap with a stall.
  assign rd_a = gpr_rd[0];
  assign rd_b = gpr_rd[1];
  assign rd_c = cop_rd[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RF_CLEAR;
      clear_idx <= '0;
      regDataA  <= '0;
      regDataB  <= '0;
      copData   <= '0;
    end else begin
      state <= state_nxt;
      if (clearing) begin
        clear_idx <= clear_idx + 1'b1;
        regDataA  <= '0;
        regDataB  <= '0;
        copData   <= '0;
      end else if (!stall) begin
        regDataA <= rd_a;
        regDataB <= rd_b;
        copData  <= rd_c;
      end
    end
  end

endmodule

// File: tb/tb_tiger_regfile.sv
// Randomized + directed bench for tiger_regfile: an abstract model queues expected outputs, a monitor checks them.
module tb_tiger_regfile;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [4:0]  readRegNumA, readRegNumB, readCopNum, writeRegNum;
  logic        writeRegEn, writeRegEnCop;
  logic [31:0] writeRegData;
  logic [31:0] regDataA, regDataB, copData;
  logic        initBusy;

  tiger_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .readRegNumA  (readRegNumA),
    .readRegNumB  (readRegNumB),
    .readCopNum   (readCopNum),
    .writeRegEn   (writeRegEn),
    .writeRegEnCop(writeRegEnCop),
    .writeRegNum  (writeRegNum),
    .writeRegData (writeRegData),
    .regDataA     (regDataA),
    .regDataB     (regDataB),
    .copData      (copData),
    .initBusy     (initBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, c;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model: architectural contents and the observable output state.
  logic [31:0] gpr [32];
  logic [31:0] cop [32];
  int          busy_left = 0;
  exp_t        cur;

  function automatic logic [31:0] gpr_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wn, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef TIGER_REGFILE_BYPASS_EN
    if (we && wn == a) return wd;
`endif
    return gpr[a];
  endfunction

  function automatic logic [31:0] cop_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wn, input logic [31:0] wd);
`ifdef TIGER_REGFILE_BYPASS_EN
    if (we && wn == a) return wd;
`endif
    return cop[a];
  endfunction

  task automatic step(input logic rst, input logic st,
                      input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                      input logic we, input logic wec,
                      input logic [4:0] wn, input logic [31:0] wd);
    reset = rst; stall = st;
    readRegNumA = ra; readRegNumB = rb; readCopNum = rc;
    writeRegEn = we; writeRegEnCop = wec; writeRegNum = wn; writeRegData = wd;
    if (rst) begin
      busy_left = 32;
      for (int i = 0; i < 32; i++) begin gpr[i] = 32'h0; cop[i] = 32'h0; end
      cur.a = 0; cur.b = 0; cur.c = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      cur.a = 0; cur.b = 0; cur.c = 0;
    end else begin
      if (!st) begin
        cur.a = gpr_read(ra, we, wn, wd);
        cur.b = gpr_read(rb, we, wn, wd);
        cur.c = cop_read(rc, wec, wn, wd);
      end
      if (we && wn != 5'd0) gpr[wn] = wd;
      if (wec) cop[wn] = wd;
    end
    cur.busy = (busy_left > 0);
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #3;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("initBusy", {31'h0, initBusy}, {31'h0, e.busy});
      check("regDataA", regDataA, e.a);
      check("regDataB", regDataB, e.b);
      check("copData",  copData,  e.c);
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(32);
    step(0, 0, 5, 0, 12, 0, 0, 0, 32'h0);
    idle(1);

    // writes during the clear window must be dropped
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 32; i++) step(0, 0, 5'(i), 5'(i), 5'(i), 1, 1, 5'(i), 32'hBAD0_0000 + i);
    idle(1);
    step(0, 0, 5, 6, 7, 0, 0, 0, 32'h0);

    step(0, 0, 0, 0, 0, 1, 0, 7, 32'hDEADBEEF);
    step(0, 0, 7, 0, 0, 0, 0, 0, 32'h0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(32);
    step(0, 0, 7, 0, 0, 0, 0, 0, 32'h0);
    idle(1);

    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(1);

    step(0, 0, 0, 0, 0, 1, 1, 3, 32'hA5A5A5A5);
    step(0, 0, 3, 3, 3, 0, 0, 0, 32'h0);
    idle(1);

    step(0, 0, 0, 9, 0, 1, 0, 9, 32'h55);
    step(0, 0, 0, 9, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 9, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 8, 0, 1, 8, 32'h77);
    step(0, 0, 0, 0, 8, 0, 0, 0, 32'h0);

    step(0, 0, 0, 0, 0, 1, 0, 4, 32'h11);
    step(0, 0, 4, 0, 0, 0, 0, 0, 32'h0);
    step(0, 1, 4, 0, 0, 1, 0, 4, 32'h22);
    step(0, 1, 4, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 4, 0, 0, 0, 0, 0, 32'h0);
    idle(1);

    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(20);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(34);

    for (int i = 0; i < 1500; i++) begin
      logic rst_r, st_r, we_r, wec_r;
      logic [4:0] ra_r, rb_r, rc_r, wn_r;
      rst_r = ($urandom_range(0, 299) == 0);
      st_r  = ($urandom_range(0, 3) == 0);
      we_r  = $urandom_range(0, 1) == 1;
      wec_r = $urandom_range(0, 2) == 0;
      ra_r  = 5'($urandom_range(0, 7));
      rb_r  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rc_r  = 5'($urandom_range(0, 7));
      wn_r  = 5'($urandom_range(0, 7));
      step(rst_r, st_r, ra_r, rb_r, rc_r, we_r, wec_r, wn_r, $urandom);
    end
    idle(2);
    repeat (2) @(posedge clk);
    #5;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
